ddr_wr_burst_ctrl: RTL and testbench

- Upstream feeder for the AXI write master. Accepts a valid/ready data stream into an internal show-ahead FIFO.
- Once a full burst is buffered, issues a write command (wr_start/wr_addr/wr_len) to the AXI write master and presents wr_data, popping one word per wr_req.
- Generates linear addresses inside a DDR frame region, wrapping at the region end. flush terminates a frame with a partial burst and rewinds to the base address.

---
 rtl/ddr_wr_burst_ctrl_pkg.sv | 24 ++
 rtl/ddr_wr_sfifo.sv | 67 ++++++
 rtl/ddr_wr_burst_ctrl.sv | 155 +++++++++++++++
 tb/tb_ddr_wr_burst_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_wr_burst_ctrl_pkg.sv
// Shared types and helpers for the DDR write burst controller.
// Holds the burst FSM encoding, error bit positions and clog2.
package ddr_wr_burst_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_BUSY,
        ST_RUN
    } wr_state_e;

    localparam int unsigned ERR_UNDERFLOW = 0;
    localparam int unsigned ERR_BEATS     = 1;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ddr_wr_sfifo.sv
// Single-clock show-ahead FIFO with occupancy output.
// Head word is visible on dout without a read latency.
module ddr_wr_sfifo
    import ddr_wr_burst_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic [DATA_WIDTH-1:0]   din,
    input  logic                    pop,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic                    full,
    output logic                    empty,
    output logic [clog2(DEPTH):0]   level
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           level_q, level_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  do_push;
    logic                  do_pop;

    assign full    = (level_q == FULL_LVL);
    assign empty   = (level_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem_q[rd_ptr_q];
    assign level   = level_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset; pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/ddr_wr_burst_ctrl.sv
// Buffers a data stream and issues bursts to the AXI write master,
// walking a wrapping frame region and rewinding on flush.
module ddr_wr_burst_ctrl
    import ddr_wr_burst_ctrl_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH   = 32,
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter int unsigned           BURST_LEN    = 16,
    parameter int unsigned           FIFO_DEPTH   = 64,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h0000_0000,
    parameter logic [ADDR_WIDTH-1:0] REGION_BYTES = 32'h0010_0000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       din_valid,
    input  logic [DATA_WIDTH-1:0]      din_data,
    output logic                       din_ready,
    input  logic                       flush,
    output logic                       wr_start,
    output logic [ADDR_WIDTH-1:0]      wr_addr,
    output logic [7:0]                 wr_len,
    output logic [DATA_WIDTH-1:0]      wr_data,
    input  logic                       wr_req,
    input  logic                       wr_busy,
    output logic [clog2(FIFO_DEPTH):0] fifo_level,
    output logic                       frame_done,
    output logic [1:0]                 err
);

    localparam int unsigned LW = clog2(FIFO_DEPTH) + 1;
    localparam logic [LW-1:0] BURST_LVL = LW'(BURST_LEN);
    localparam logic [7:0] FULL_LEN = 8'(BURST_LEN);
    localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] REGION_END = BASE_ADDR + REGION_BYTES;

    wr_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic                  final_q, final_d;
    logic                  flush_pend_q, flush_pend_d;
    logic [8:0]            beat_q, beat_d;
    logic [1:0]            err_q, err_d;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [LW-1:0]         level;
    logic [ADDR_WIDTH-1:0] addr_sum;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic [8:0]            beats_now;

    ddr_wr_sfifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (din_valid),
        .din   (din_data),
        .pop   (wr_req),
        .dout  (wr_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign din_ready  = ~fifo_full;
    assign fifo_level = level;
    assign wr_addr    = addr_q;
    assign wr_len     = len_q;
    assign err        = err_q;

    assign addr_sum  = addr_q + ADDR_WIDTH'(len_q) * BEAT_BYTES;
    assign addr_next = (addr_sum >= REGION_END) ? BASE_ADDR : addr_sum;
    // Include a request landing in the same cycle busy drops.
    assign beats_now = beat_q + {8'd0, wr_req};

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        len_d        = len_q;
        final_d      = final_q;
        flush_pend_d = flush_pend_q;
        beat_d       = beat_q;
        err_d        = err_q;
        wr_start     = 1'b0;
        frame_done   = 1'b0;

        if (wr_req && fifo_empty) err_d[ERR_UNDERFLOW] = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (level >= BURST_LVL) begin
                    len_d   = FULL_LEN;
                    final_d = 1'b0;
                    state_d = ST_START;
                end else if (flush_pend_q && level != '0) begin
                    len_d   = 8'(level);
                    final_d = 1'b1;
                    state_d = ST_START;
                end else if (flush_pend_q) begin
                    flush_pend_d = 1'b0;
                    addr_d       = BASE_ADDR;
                    frame_done   = 1'b1;
                end
            end
            ST_START: begin
                wr_start = 1'b1;
                beat_d   = '0;
                state_d  = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                beat_d = beats_now;
                if (wr_busy) state_d = ST_RUN;
            end
            ST_RUN: begin
                beat_d = beats_now;
                if (!wr_busy) begin
                    if (beats_now != {1'b0, len_q}) err_d[ERR_BEATS] = 1'b1;
                    addr_d = addr_next;
                    if (final_q) begin
                        addr_d       = BASE_ADDR;
                        flush_pend_d = 1'b0;
                        frame_done   = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A new flush always wins over the clear from a finishing frame.
        if (flush) flush_pend_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= BASE_ADDR;
            len_q        <= '0;
            final_q      <= 1'b0;
            flush_pend_q <= 1'b0;
            beat_q       <= '0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            final_q      <= final_d;
            flush_pend_q <= flush_pend_d;
            beat_q       <= beat_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_ddr_wr_burst_ctrl.sv
// Directed-random bench for ddr_wr_burst_ctrl with a write-master model
// and a queue-based reference for data, burst lengths and addresses.
module tb_ddr_wr_burst_ctrl;

    localparam int BL  = 16;
    localparam int REG = 'h80;
    localparam int BPB = 4;

    logic        clk;
    logic        rst_n;
    logic        din_valid;
    logic [31:0] din_data;
    logic        din_ready;
    logic        flush;
    logic        wr_start;
    logic [31:0] wr_addr;
    logic [7:0]  wr_len;
    logic [31:0] wr_data;
    logic        wr_req;
    logic        wr_busy;
    logic [6:0]  fifo_level;
    logic        frame_done;
    logic [1:0]  err;

    logic m_req;
    logic tb_req;
    assign wr_req = m_req | tb_req;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] q[$];
    int uncommitted = 0;
    int exp_addr    = 0;
    int n_bursts    = 0;
    int fd_cnt      = 0;
    int manual_beats = 0;
    bit stall      = 0;
    bit short_mode = 0;
    bit m_active   = 0;

    ddr_wr_burst_ctrl #(
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (32),
        .BURST_LEN    (BL),
        .FIFO_DEPTH   (64),
        .BASE_ADDR    (32'h0),
        .REGION_BYTES (32'h80)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_valid  (din_valid),
        .din_data   (din_data),
        .din_ready  (din_ready),
        .flush      (flush),
        .wr_start   (wr_start),
        .wr_addr    (wr_addr),
        .wr_len     (wr_len),
        .wr_data    (wr_data),
        .wr_req     (wr_req),
        .wr_busy    (wr_busy),
        .fifo_level (fifo_level),
        .frame_done (frame_done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && frame_done) fd_cnt++;
    end

    // Write master model: busy the cycle after wr_start, random beat gaps.
    initial begin
        int n;
        int nb;
        int el;
        m_req   = 1'b0;
        wr_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && wr_start) begin
                m_active = 1;
                n_bursts++;
                n  = int'(wr_len);
                el = (uncommitted >= BL) ? BL : uncommitted;
                check("burst_len", wr_len, el);
                check("burst_addr", wr_addr, exp_addr);
                uncommitted -= el;
                if (el < BL) exp_addr = 0;
                else exp_addr = (exp_addr + el * BPB) % REG;
                @(posedge clk); #1;
                wr_busy = rst_n;
                while (stall && rst_n) begin
                    @(posedge clk); #1;
                end
                nb = n - manual_beats - (short_mode ? 1 : 0);
                manual_beats = 0;
                for (int i = 0; i < nb && rst_n; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                    end
                    if (rst_n) begin
                        m_req = 1'b1;
                        #1;
                        if (q.size() > 0) check("wr_data", wr_data, q.pop_front());
                        else check("model_q_nonempty", 0, 1);
                        @(posedge clk); #1;
                        m_req = 1'b0;
                    end
                end
                m_req = 1'b0;
                if (short_mode && rst_n) uncommitted += 1;
                repeat ($urandom_range(1, 6)) begin
                    @(posedge clk); #1;
                end
                wr_busy = 1'b0;
                if (rst_n) begin
                    @(posedge clk); #1;
                end
                m_active = 0;
            end
        end
    end

    task automatic push_word(input logic [31:0] d);
        int t;
        t = 0;
        din_valid = 1'b1;
        din_data  = d;
        while (!din_ready && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 500) check("push_timeout", 1, 0);
        @(posedge clk);
        q.push_back(d);
        uncommitted++;
        #1;
        din_valid = 1'b0;
    endtask

    task automatic settle(input string tag);
        int stable;
        int t;
        stable = 0;
        t = 0;
        while (stable < 4 && t < 3000) begin
            @(negedge clk);
            t++;
            if (!m_active && !wr_start && uncommitted < BL) stable++;
            else stable = 0;
        end
        check(tag, (t < 3000), 1);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q.delete();
        uncommitted  = 0;
        exp_addr     = 0;
        manual_beats = 0;
        stall        = 0;
        short_mode   = 0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int fd0;
        int nb0;
        int t;
        logic [31:0] d;
        rst_n     = 1'b0;
        din_valid = 1'b0;
        din_data  = '0;
        flush     = 1'b0;
        tb_req    = 1'b0;
        #1;
        check("rst_wr_start", wr_start, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_len", wr_len, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_err", err, 0);
        check("rst_level", fifo_level, 0);
        check("rst_din_ready", din_ready, 1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // single burst with counting data
        nb0 = n_bursts;
        fd0 = fd_cnt;
        for (int i = 1; i <= 16; i++) push_word(32'(i));
        settle("t1_settle");
        check("t1_bursts", n_bursts - nb0, 1);
        check("t1_next_addr", wr_addr, 32'h40);
        check("t1_level", fifo_level, q.size());
        check("t1_frame_done", fd_cnt - fd0, 0);
        check("t1_err", err, 0);

        // region wrap across three bursts
        do_reset();
        nb0 = n_bursts;
        for (int i = 0; i < 48; i++) push_word($urandom);
        settle("t2_settle");
        check("t2_bursts", n_bursts - nb0, 3);
        check("t2_addr", wr_addr, exp_addr);
        check("t2_addr_abs", wr_addr, 32'h40);
        check("t2_err", err, 0);
        check("t2_level", fifo_level, 0);

        // partial burst on flush
        do_reset();
        nb0 = n_bursts;
        fd0 = fd_cnt;
        for (int i = 0; i < 20; i++) push_word($urandom);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        settle("t3_settle");
        check("t3_bursts", n_bursts - nb0, 2);
        check("t3_frame_done", fd_cnt - fd0, 1);
        check("t3_addr_rewind", wr_addr, 0);
        check("t3_level", fifo_level, 0);
        check("t3_err", err, 0);

        // short beat count
        short_mode = 1;
        for (int i = 0; i < 16; i++) push_word($urandom);
        settle("t4a_settle");
        short_mode = 0;
        check("t4_err_beats", err, 2'b10);
        check("t4_level_left", fifo_level, q.size());
        nb0 = n_bursts;
        for (int i = 0; i < 16; i++) push_word($urandom);
        settle("t4b_settle");
        check("t4_next_burst", n_bursts - nb0, 1);
        check("t4_err_sticky", err, 2'b10);
        check("t4_addr", wr_addr, exp_addr);

        // fill while master stalled, then simultaneous push/pop
        do_reset();
        stall = 1;
        for (int i = 0; i < 64; i++) push_word($urandom);
        check("t5_full_level", fifo_level, 64);
        check("t5_full_ready", din_ready, 0);
        din_valid = 1'b1;
        din_data  = $urandom;
        @(posedge clk); #1;
        din_valid = 1'b0;
        check("t5_full_hold", fifo_level, 64);
        tb_req = 1'b1;
        #1;
        check("t5_pop_data", wr_data, q[0]);
        @(posedge clk);
        void'(q.pop_front());
        #1;
        tb_req = 1'b0;
        check("t5_pop_level", fifo_level, 63);
        check("t5_ready_back", din_ready, 1);
        d = $urandom;
        din_valid = 1'b1;
        din_data  = d;
        tb_req    = 1'b1;
        #1;
        check("t5_pp_data", wr_data, q[0]);
        @(posedge clk);
        void'(q.pop_front());
        q.push_back(d);
        uncommitted++;
        #1;
        din_valid = 1'b0;
        tb_req    = 1'b0;
        check("t5_pp_level", fifo_level, 63);
        manual_beats = 2;
        stall = 0;
        settle("t5_settle");
        check("t5_level", fifo_level, q.size());
        check("t5_addr", wr_addr, exp_addr);
        check("t5_err", err, 0);

        // reset mid-burst
        do_reset();
        for (int i = 0; i < 16; i++) push_word($urandom);
        t = 0;
        while (!wr_busy && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        check("t6_busy_seen", wr_busy, 1);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_wr_start", wr_start, 0);
        check("t6_wr_addr", wr_addr, 0);
        check("t6_wr_len", wr_len, 0);
        check("t6_frame_done", frame_done, 0);
        check("t6_err", err, 0);
        check("t6_level", fifo_level, 0);
        @(posedge clk); #1;
        do_reset();
        repeat (4) @(posedge clk);
        #1;
        check("t6_post_level", fifo_level, 0);
        check("t6_post_addr", wr_addr, 0);
        check("t6_post_master_idle", m_active, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
